// File: rtl/out_port_arbiter_pkg.sv
// Shared definitions for the output-port arbiter: FSM encoding and default port width.
package out_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int unsigned PORT_DATA_W = 8;

endpackage

// File: rtl/out_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning from rr_ptr upward, wrapping.
module rr_picker
  import out_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  int unsigned w_idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = k + 32'(rr_ptr);
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!valid && req[PTR_W'(w_idx)]) begin
        valid  = 1'b1;
        winner = PTR_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter sharing one OutputPort register: one latched write per grant,
// followed by an optional hold window.
module out_port_arbiter
  import out_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = PORT_DATA_W,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          ack,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        port_enable,
  output logic [DATA_W-1:0]           port_data
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  state_t            r_state;
  state_t            w_next_state;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [PTR_W-1:0]  r_grant_id;
  logic [PTR_W-1:0]  w_winner;
  logic              w_valid;
  logic [DATA_W-1:0] r_port_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    ack          = '0;
    busy         = 1'b0;
    port_enable  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        busy            = 1'b1;
        port_enable     = 1'b1;
        ack[r_grant_id] = 1'b1;
        w_next_state    = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (r_cnt <= CNT_W'(1)) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Grant data is captured on the IDLE->WRITE edge so requester changes during WRITE are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_port_data <= '0;
      r_cnt       <= '0;
    end else begin
      if (r_state == ST_IDLE && w_valid) begin
        r_grant_id  <= w_winner;
        r_port_data <= w_wdata_arr[w_winner];
        r_rr_ptr    <= (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
      end
      if (r_state == ST_WRITE)
        r_cnt <= CNT_W'(HOLD_CYCLES);
      else if (r_state == ST_HOLD && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign grant_id  = r_grant_id;
  assign port_data = r_port_data;

endmodule
